// File: rtl/face_detect_mul_pkg.sv
// Shared widths, default sizing and the result record for the shared-multiplier arbiter.
package face_detect_mul_pkg;

    localparam int A_W         = 16;
    localparam int B_W         = 10;
    localparam int P_W         = 26;
    localparam int NUM_REQ_DEF = 4;
    localparam int MUL_LAT_DEF = 3;
    // Widest id needed for the largest supported requester count (8).
    localparam int ID_W_MAX    = 3;

    typedef struct packed {
        logic signed [P_W-1:0] data;
        logic [ID_W_MAX-1:0]   id;
    } res_t;

endpackage

// File: rtl/face_detect_mul_arb_if.sv
// Requester/result bus of face_detect_mul_arb; master drives operands, slave returns products.
interface face_detect_mul_arb_if
    import face_detect_mul_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W   = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   res_valid;
    logic                   res_ready;
    logic signed [P_W-1:0]  res_data;
    logic [ID_W-1:0]        res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );

endinterface

// File: rtl/face_detect_rr_arb.sv
// Round-robin arbiter (search starts after the last accepted index); defining
// FACE_DETECT_MUL_ARB_FIXED_PRIO_EN turns it into a lowest-index-wins priority encoder.
module face_detect_rr_arb
    import face_detect_mul_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int ID_W = $clog2(NUM_REQ);

`ifdef FACE_DETECT_MUL_ARB_FIXED_PRIO_EN

    logic unused_ok;
    assign unused_ok = ^{clk, reset, adv_i};

    always_comb begin
        gnt_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end

`else

    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;

    // Walk farthest-first so the candidate closest after last_q overwrites the rest.
    always_comb begin
        gnt_o = '0;
        idx   = '0;
        win   = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                win        = idx;
            end
        end
        last_d = adv_i ? win : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= ID_W'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule

// File: rtl/face_detect_mul_arb.sv
// Shares one external pipelined multiplier among NUM_REQ requesters and returns products in
// issue order; FACE_DETECT_MUL_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module face_detect_mul_arb
    import face_detect_mul_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*A_W-1:0]  req_a,
    input  logic [NUM_REQ*B_W-1:0]  req_b,
    output logic                    mul_ce,
    output logic [A_W-1:0]          mul_din0,
    output logic signed [B_W-1:0]   mul_din1,
    input  logic signed [P_W-1:0]   mul_dout,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [P_W-1:0]   res_data,
    output logic [ID_W-1:0]         res_id
);

    logic               stall;
    logic [NUM_REQ-1:0] gnt;
    logic               issue;
    logic [ID_W-1:0]    issue_id;
    logic [MUL_LAT-1:0] vld_p_q, vld_p_d;
    logic [ID_W-1:0]    id_p_q [MUL_LAT];
    logic               load;
    res_t               res_q, res_d;
    logic               res_valid_q, res_valid_d;
    logic               unused_id_hi;

    // A held, unread result freezes everything upstream, multiplier included.
    assign stall  = res_valid_q && !res_ready;
    assign mul_ce = !reset && !stall;

    face_detect_rr_arb #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (req_valid),
        .adv_i (issue),
        .gnt_o (gnt)
    );

    assign req_ready = mul_ce ? gnt : '0;
    assign issue     = |req_ready;

    // Stage p0: operand issue to the multiplier
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        issue_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                mul_din0 = req_a[A_W*i +: A_W];
                mul_din1 = $signed(req_b[B_W*i +: B_W]);
                issue_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        vld_p_d    = '0;
        vld_p_d[0] = issue;
        for (int k = 1; k < MUL_LAT; k++) begin
            vld_p_d[k] = vld_p_q[k-1];
        end
    end

    // Stage p1..pN: valid/id shadow of the multiplier pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p_q <= '0;
        end else if (mul_ce) begin
            vld_p_q <= vld_p_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mul_ce) begin
            id_p_q[0] <= issue_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                id_p_q[k] <= id_p_q[k-1];
            end
        end
    end

    // Stage out: one-entry result register, reloadable in the same cycle it is drained
    assign load = mul_ce && vld_p_q[MUL_LAT-1];

    always_comb begin
        res_d       = res_q;
        res_valid_d = res_valid_q;
        if (load) begin
            res_valid_d = 1'b1;
            res_d.data  = mul_dout;
            res_d.id    = ID_W_MAX'(id_p_q[MUL_LAT-1]);
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_data     = res_q.data;
    assign res_id       = res_q.id[ID_W-1:0];
    assign unused_id_hi = ^res_q.id;

endmodule

// File: tb/tb_face_detect_mul_arb.sv
// Scoreboard bench for face_detect_mul_arb with a behavioural MUL_LAT-stage multiplier.
module tb_face_detect_mul_arb;
    import face_detect_mul_pkg::*;

    localparam int NR  = 4;
    localparam int LAT = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  mul_ce;
    logic [15:0]           mul_din0;
    logic signed [9:0]     mul_din1;
    logic signed [25:0]    mul_dout;
    logic signed [25:0]    mpipe [LAT];

    face_detect_mul_arb_if #(.NUM_REQ(NR)) bus ();

    face_detect_mul_arb #(
        .NUM_REQ (NR),
        .MUL_LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (bus.req_valid),
        .req_ready (bus.req_ready),
        .req_a     (bus.req_a),
        .req_b     (bus.req_b),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .res_valid (bus.res_valid),
        .res_ready (bus.res_ready),
        .res_data  (bus.res_data),
        .res_id    (bus.res_id)
    );

    always #5 clk = ~clk;

    // External multiplier: operands sampled on a ce edge, product LAT ce edges later.
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= 26'(int'($signed({1'b0, mul_din0})) * int'(mul_din1));
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_dout = mpipe[LAT-1];

    int checks = 0;
    int errors = 0;
    logic signed [25:0] exp_data_q [$];
    int                 exp_id_q   [$];

    logic [15:0]        ta  [NR][4];
    logic signed [9:0]  tbv [NR][4];
    logic signed [25:0] tp  [NR][4];
    int                 tcnt [NR];
    int                 tpos [NR];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input int k, input logic [15:0] a,
                        input logic signed [9:0] b, input logic signed [25:0] p);
        ta[i][k]  = a;
        tbv[i][k] = b;
        tp[i][k]  = p;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %0d id %0d expected none",
                         bus.res_data, bus.res_id);
            end else begin
                check("res_data", bus.res_data, exp_data_q.pop_front());
                check("res_id", bus.res_id, exp_id_q.pop_front());
            end
        end
        if (|bus.req_ready) check("onehot_grant", $countones(bus.req_ready), 1);
    end

    task automatic run(input int cycles, input int stall_from, input int stall_len,
                       input bit chk_order);
        int gcount;
        gcount = 0;
        for (int c = 0; c < cycles; c++) begin
            bus.res_ready = !(c >= stall_from && c < stall_from + stall_len);
            for (int i = 0; i < NR; i++) begin
                bus.req_valid[i] = tpos[i] < tcnt[i];
                if (tpos[i] < tcnt[i]) begin
                    bus.req_a[16*i +: 16] = ta[i][tpos[i]];
                    bus.req_b[10*i +: 10] = tbv[i][tpos[i]];
                end
            end
            @(negedge clk);
            if (!bus.res_ready) begin
                check("stall_mul_ce", mul_ce, 0);
                check("stall_no_grant", bus.req_ready, 0);
            end
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_data_q.push_back(tp[i][tpos[i]]);
                    exp_id_q.push_back(i);
`ifndef FACE_DETECT_MUL_ARB_FIXED_PRIO_EN
                    if (chk_order) check("rr_order", i, gcount % NR);
`endif
                    gcount++;
                    tpos[i]++;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
    endtask

    task automatic drain(input int budget);
        bus.res_ready = 1'b1;
        for (int c = 0; c < budget && exp_data_q.size() != 0; c++) @(posedge clk);
        check("drain_empty", exp_data_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic single_issue(input int id, input logic [15:0] a, input logic signed [9:0] b,
                                input logic signed [25:0] p, input logic [NR-1:0] exp_rdy);
        int lat;
        lat = 0;
        bus.req_valid            = '0;
        bus.req_valid[id]        = 1'b1;
        bus.req_a[16*id +: 16]   = a;
        bus.req_b[10*id +: 10]   = b;
        @(negedge clk);
        check("single_grant", bus.req_ready, exp_rdy);
        exp_data_q.push_back(p);
        exp_id_q.push_back(id);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, 4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            tcnt[i] = 0;
            tpos[i] = 0;
        end
        setv(0, 0, 16'd1000, -10'sd3, -26'sd3000);
        setv(0, 1, 16'd2, 10'sd5, 26'sd10);
        setv(0, 2, 16'd100, -10'sd100, -26'sd10000);
        setv(0, 3, 16'd7, 10'sd7, 26'sd49);
        setv(1, 0, 16'd1, 10'sd1, 26'sd1);
        setv(1, 1, 16'd300, -10'sd2, -26'sd600);
        setv(1, 2, 16'd65535, -10'sd512, -26'sd33553920);
        setv(1, 3, 16'd0, -10'sd512, 26'sd0);
        setv(2, 0, 16'd12, 10'sd12, 26'sd144);
        setv(2, 1, 16'd65535, 10'sd511, 26'sd33488385);
        setv(2, 2, 16'd40, -10'sd1, -26'sd40);
        setv(2, 3, 16'd250, 10'sd4, 26'sd1000);
        setv(3, 0, 16'd3, -10'sd7, -26'sd21);
        setv(3, 1, 16'd1000, 10'sd100, 26'sd100000);
        setv(3, 2, 16'd9, -10'sd9, -26'sd81);
        setv(3, 3, 16'd65535, -10'sd1, -26'sd65535);

        // Reset state, with every requester asking.
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '1;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_mul_ce", mul_ce, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_id", bus.res_id, 0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_mul_ce", mul_ce, 1);
        check("idle_din0", mul_din0, 0);
        check("idle_din1", mul_din1, 0);
        @(posedge clk);
        #1;

        // Single request, req0 a=1000 b=-3.
        single_issue(0, 16'd1000, -10'sd3, -26'sd3000, 4'b0001);
        drain(20);

        // Contention with a 5-cycle backpressure window.
        do_reset(2);
        for (int i = 0; i < NR; i++) begin
            tcnt[i] = 4;
            tpos[i] = 0;
        end
        run(26, 6, 5, 1'b1);
        drain(40);

        // Reset with three products in flight.
        tcnt[0] = 3;
        tpos[0] = 0;
        for (int i = 1; i < NR; i++) begin
            tcnt[i] = 0;
            tpos[i] = 0;
        end
        run(3, 1000, 0, 1'b0);
        reset = 1'b1;
        exp_data_q.delete();
        exp_id_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("post_reset_quiet", bus.res_valid, 0);
        end
        @(posedge clk);
        #1;
        single_issue(2, 16'd250, 10'sd4, 26'sd1000, 4'b0100);
        drain(20);

        // req1 and req3 both pending.
        do_reset(2);
        bus.req_valid = 4'b1010;
        bus.req_a[16 +: 16] = 16'd2;
        bus.req_b[10 +: 10] = 10'sd3;
        bus.req_a[48 +: 16] = 16'd2;
        bus.req_b[30 +: 10] = 10'sd3;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
`ifdef FACE_DETECT_MUL_ARB_FIXED_PRIO_EN
            check("prio_grant", bus.req_ready, 4'b0010);
            exp_id_q.push_back(1);
`else
            check("rr_pair_grant", bus.req_ready, (c % 2 == 0) ? 4'b0010 : 4'b1000);
            exp_id_q.push_back((c % 2 == 0) ? 1 : 3);
`endif
            exp_data_q.push_back(26'sd6);
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
